num_split_seq: RTL and testbench
================================

// Module: num_split_seq
// PURPOSE
//  Sequential binary-to-decimal splitter for the calculator datapath. Takes one unsigned
//  binary result (e.g. v_res) per handshake and converts it by shift-and-add-3 (double dabble).
//  Returns DIGITS packed BCD digits, most significant digit in the top nibble.
//  Counterpart of num_join: joins digits into a number upstream, this block splits the
//  arithmetic result back into digits for display/readback. Replaces combinational /10 %10.
// PARAMETERS
//  IN_W    8  width of binary input, >=1
//  DIGITS  3  number of BCD output digits, >=1
// PORTS
//  clk        in   1           single clock; all state changes on rising edge
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           in_data is valid
//  in_ready   out  1           block can accept in_data
//  in_data    in   IN_W        unsigned binary value to split
//  out_valid  out  1           out_bcd/out_ovf are valid
//  out_ready  in   1           consumer accepts output
//  out_bcd    out  4*DIGITS    BCD digits; [3:0]=units, [7:4]=tens, ...
//  out_ovf    out  1           value >= 10**DIGITS; out_bcd holds value mod 10**DIGITS
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; in_ready=1, out_valid=0, out_bcd=0, out_ovf=0, count=0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: in_ready=1. in_valid&in_ready at edge: load bin=in_data, bcd=0, ovf=0, count=IN_W -> SHIFT.
//  SHIFT: in_ready=0. Each edge does one step:
//   - every digit nibble >=5 gets +3;
//   - then {bcd,bin} shifts left 1;
//   - ovf |= bit shifted out of the top bcd nibble;
//   - count-=1; when count reaches 0 -> DONE.
//  DONE: out_valid=1; out_bcd/out_ovf stable and held while out_ready=0 (no timeout).
//   out_valid&out_ready at edge -> IDLE, out_valid=0. out_bcd keeps its last value.
//  Latency: out_valid rises exactly IN_W cycles after the accepting edge.
//   Throughput: one conversion per IN_W+2 cycles. in_ready is never high in the same cycle as out_valid.
//  in_data is sampled only at the accept edge; later changes are ignored.
//   in_valid with in_ready=0 is not lost: upstream holds it (valid/ready rule).
//  Input 0 gives out_bcd=0, out_ovf=0. Max input 2**IN_W-1 converts exactly if DIGITS is sufficient.
//  Nibble values never exceed 9 at the output. No add-3 is applied after the final shift.
//  rst mid-SHIFT or mid-DONE: conversion is aborted, the result is discarded, the reset values apply,
//   and no out_valid pulse is produced for the aborted value.
//  rst has priority over every handshake in the same cycle.
// STRUCTURE
//  calc_pkg (shared):
//   - state encoding IDLE/SHIFT/DONE;
//   - BCD_W=4, ADJ_THRESH=5, ADJ_ADD=3;
//   - function cnt_w(IN_W)=$clog2(IN_W+1).
//  Sub-module bcd_digit_adj: 4-bit combinational in -> in>=5 ? in+3 : in.
//   Instantiated DIGITS times via generate.
//  Top: FSM, count, bin/bcd shift registers, ovf flag, handshake logic.
// TESTING
//  1: IN_W=8,DIGITS=3; in_data=35 -> out_bcd=12'h035, ovf=0, out_valid 8 cycles after accept.
//  2: in_data=255 -> 12'h255, ovf=0. in_data=0 -> 12'h000. in_data=100 -> 12'h100.
//  3: DIGITS=2, in_data=123 -> out_bcd=8'h23, ovf=1. Then in_data=99 -> 8'h99, ovf=0 (flag cleared).
//  4: out_ready=0 for 20 cycles in DONE -> out_valid, out_bcd, ovf stable, in_ready=0;
//     then 1 cycle out_ready -> IDLE.
//  5: rst pulse at shift step 4 of 35 -> no out_valid; next input 12 -> 12'h012.
//  6: back-to-back in_valid=1 with 12, 23, 35 and out_ready=1 -> three results in order;
//     accepts spaced IN_W+2 cycles; scoreboard checks all 0..255 against /10,%10 model.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared calculator definitions. Holds the splitter state
//                encoding, BCD adjust constants and the counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  // Converter sequencing: accept a value, shift it through, present result
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BCD_W      = 4;  // bits per decimal digit
  localparam int ADJ_THRESH = 5;  // digit value that would exceed 9 once doubled
  localparam int ADJ_ADD    = 3;  // correction so the doubling carries into the next digit

  // Width needed to hold a down-counter starting at in_w
  function automatic int cnt_w(input int in_w);
    return $clog2(in_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Add-3 correction for one BCD digit ahead of a left shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  // Digits of 5 or more would reach 10+ after doubling, so pre-bias by 3
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_W'(ADJ_THRESH)) begin
      digit_o = digit_i + BCD_W'(ADJ_ADD);
    end
  end

endmodule
`default_nettype wire

// File: rtl/num_split_seq.sv
`default_nettype none
// ============================================================================
//  Module      : num_split_seq
//  Description : Sequential binary to packed-BCD splitter (double dabble).
//                One bit is consumed per clock; the result is held with a
//                valid/ready handshake. Digits beyond DIGITS are reported
//                through out_ovf while out_bcd holds value mod 10**DIGITS.
//  Revision    : 1.0 - initial release
// ============================================================================
module num_split_seq
  import calc_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BCD_W*DIGITS-1:0] out_bcd,
  output logic                    out_ovf
);

  localparam int CW      = cnt_w(IN_W);
  localparam int BCD_TOT = BCD_W * DIGITS;

  state_e               state_q, state_d;
  logic [IN_W-1:0]      bin_q, bin_d;
  logic [BCD_TOT-1:0]   bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [CW-1:0]        count_q, count_d;
  logic [BCD_TOT-1:0]   bcd_adj;

  // Per-digit add-3 correction applied to the current BCD register
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[BCD_W*g +: BCD_W]),
      .digit_o (bcd_adj[BCD_W*g +: BCD_W])
    );
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_d   = in_data;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          count_d = CW'(IN_W);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Adjust then shift {bcd,bin} left; anything leaving the top digit
        // means the value does not fit in DIGITS decimal digits
        bin_d   = bin_q << 1;
        bcd_d   = {bcd_adj[BCD_TOT-2:0], bin_q[IN_W-1]};
        ovf_d   = ovf_q | bcd_adj[BCD_TOT-1];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign out_bcd = bcd_q;
  assign out_ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_num_split_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_num_split_seq
//  Description : Self-checking bench for num_split_seq (3-digit and 2-digit
//                instances) with a queue-based scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_num_split_seq;

  localparam int IN_W   = 8;
  localparam int DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_bcd;
  logic        out_ovf;

  logic        in2_valid = 1'b0;
  logic        in2_ready;
  logic [7:0]  in2_data = '0;
  logic        out2_valid;
  logic        out2_ready = 1'b1;
  logic [7:0]  out2_bcd;
  logic        out2_ovf;

  always #5 clk = ~clk;

  num_split_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_ovf(out_ovf)
  );

  num_split_seq #(.IN_W(IN_W), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data),
    .out_valid(out2_valid), .out_ready(out2_ready),
    .out_bcd(out2_bcd), .out_ovf(out2_ovf)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: decimal digits by /10 and %10
  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   last_acc = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the 3-digit instance
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_t e;
        e.bcd = to_bcd(int'(in_data), DIGITS);
        e.ovf = (int'(in_data) >= 1000);
        sb.push_back(e);
        last_acc = cyc + 1;
      end
      if (out_valid && !ov_prev)
        chk_eq("latency", cyc - last_acc, IN_W);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk_eq("sb_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk_eq("out_bcd", {20'h0, out_bcd}, e.bcd);
          chk_eq("out_ovf", {31'h0, out_ovf}, {31'h0, e.ovf});
        end
      end
      chk_eq("ready_valid_excl", {31'h0, in_ready & out_valid}, 0);
    end
    ov_prev = out_valid;
  end

  task automatic send3(input int v);
    int n;
    @(posedge clk); #1;
    in_data  = 8'(v);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk_eq("accept_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain", sb.size(), 0);
  endtask

  task automatic run2(input int v);
    int n;
    @(posedge clk); #1;
    in2_data  = 8'(v);
    in2_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in2_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in2_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out2_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_eq("d2_valid", {31'h0, out2_valid}, 1);
    chk_eq("d2_bcd", {24'h0, out2_bcd}, to_bcd(v, 2));
    chk_eq("d2_ovf", {31'h0, out2_ovf}, {31'h0, (v >= 100)});
  endtask

  initial begin
    int   n;
    int   acc;
    int   prev;
    logic saw;
    int   vals[$];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_in_ready", {31'h0, in_ready}, 1);
    chk_eq("rst_out_valid", {31'h0, out_valid}, 0);
    chk_eq("rst_out_bcd", {20'h0, out_bcd}, 0);
    chk_eq("rst_out_ovf", {31'h0, out_ovf}, 0);
    chk_eq("rst2_out_valid", {31'h0, out2_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic values, including zero and the maximum input
    send3(35);
    send3(255);
    send3(0);
    send3(100);
    drain();

    // Output held while consumer stalls
    out_ready = 1'b0;
    send3(77);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (20) begin
      @(negedge clk);
      chk_eq("hold_valid", {31'h0, out_valid}, 1);
      chk_eq("hold_bcd", {20'h0, out_bcd}, 32'h077);
      chk_eq("hold_ovf", {31'h0, out_ovf}, 0);
      chk_eq("hold_in_ready", {31'h0, in_ready}, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk_eq("post_hold_valid", {31'h0, out_valid}, 0);
    chk_eq("post_hold_in_ready", {31'h0, in_ready}, 1);
    chk_eq("post_hold_bcd_kept", {20'h0, out_bcd}, 32'h077);
    chk_eq("post_hold_sb", sb.size(), 0);
    out_ready = 1'b1;

    // Reset during the shift phase aborts the conversion
    send3(35);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_eq("abort_in_ready", {31'h0, in_ready}, 1);
    chk_eq("abort_bcd", {20'h0, out_bcd}, 0);
    saw = 1'b0;
    repeat (IN_W + 4) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk_eq("abort_no_valid", {31'h0, saw}, 0);
    send3(12);
    drain();

    // Back-to-back stream: 12, 23, 35 then every input value
    vals.push_back(12);
    vals.push_back(23);
    vals.push_back(35);
    for (int v = 0; v < 256; v++) vals.push_back(v);
    prev = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int k = 0; k < vals.size(); k++) begin
      in_data = 8'(vals[k]);
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) chk_eq("stream_timeout", 1, 0);
      acc = cyc + 1;
      if (k > 0) chk_eq("spacing", acc - prev, IN_W + 2);
      prev = acc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Two-digit instance: overflow set, then cleared by the next value
    run2(123);
    run2(99);
    run2(100);
    run2(255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
